// File: rtl/pwm_fade.sv
// Brightness fader for pwm_ctrl: walks level one step toward a target every (rate+1) PWM periods, or jumps at rate 15.
// Latency: a new level appears on the edge where the period counter wraps 254->0, so it is stable for a whole period.
// Backpressure: tgt_ready is high only while idle; tgt_valid seen while busy is dropped, never queued.
//
// Ports: clk, rstn (sync, active-low), tgt_level/tgt_rate/tgt_valid/tgt_ready (target handshake),
//        level (registered, feeds pwm_ctrl.level), period_start (counter == 0), busy (ramp in progress).
// Optional: define PWM_FADE_BREATHE_EN to add the breathe input, which auto-reverses ramps between 0 and the held target.
module pwm_fade (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tgt_level,
    input  logic       tgt_valid,
    input  logic [3:0] tgt_rate,
`ifdef PWM_FADE_BREATHE_EN
    input  logic       breathe,
`endif
    output logic       tgt_ready,
    output logic [7:0] level,
    output logic       period_start,
    output logic       busy
);

    typedef enum logic {IDLE, RAMP} state_t;

    localparam logic [7:0] CNT_LAST  = 8'd254;
    localparam logic [3:0] RATE_JUMP = 4'd15;

    state_t     state;
    logic [7:0] cnt;        // period counter, mirrors pwm_ctrl's 0..254 sequence
    logic [3:0] presc;      // periods elapsed since the last step
    logic [3:0] rate_q;     // latched periods-per-step minus 1
    logic [7:0] hold_tgt;   // target as accepted from the host
    logic [7:0] dest;       // goal of the ramp currently running (differs from hold_tgt only while breathing)

    logic       boundary;
    logic       do_step;
    logic [7:0] step_level;
    logic [7:0] next_level;

    // The edge where cnt goes 254->0 is the only edge allowed to move level.
    assign boundary = (cnt == CNT_LAST);

    // In RAMP, level != dest always holds, so a single +/-1 can neither
    // overshoot nor wrap past 0/255.
    assign step_level = (level < dest) ? level + 8'd1 : level - 8'd1;
    assign next_level = (rate_q == RATE_JUMP) ? dest : step_level;
    assign do_step    = boundary && ((rate_q == RATE_JUMP) || (presc == rate_q));

    assign period_start = (cnt == 8'd0);
    assign tgt_ready    = (state == IDLE);
    assign busy         = (state == RAMP);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            presc    <= 4'd0;
            rate_q   <= 4'd0;
            hold_tgt <= 8'd0;
            dest     <= 8'd0;
            level    <= 8'd0;
        end else begin
            cnt <= boundary ? 8'd0 : cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        hold_tgt <= tgt_level;
                        dest     <= tgt_level;
                        rate_q   <= tgt_rate;
                        presc    <= 4'd0;
                        // Already at the requested level: nothing to ramp, busy never rises.
                        if (tgt_level != level)
                            state <= RAMP;
                    end
                end

                RAMP: begin
                    if (do_step) begin
                        level <= next_level;
                        presc <= 4'd0;
                        if (next_level == dest) begin
`ifdef PWM_FADE_BREATHE_EN
                            // Keep cycling between 0 and the held target at the same rate.
                            // A held target of 0 has nothing to breathe toward, so it settles.
                            if (breathe && (hold_tgt != 8'd0))
                                dest <= (next_level == hold_tgt) ? 8'd0 : hold_tgt;
                            else
                                state <= IDLE;
`else
                            state <= IDLE;
`endif
                        end
                    end else if (boundary) begin
                        presc <= presc + 4'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_fade.sv
// Bench for pwm_fade: directed vector table for the main ramp/jump/handshake behaviour,
// followed by hand sequences for mid-ramp reset and (when compiled with PWM_FADE_BREATHE_EN) breathing.
module tb_pwm_fade;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tgt_level = 8'd0;
    logic       tgt_valid = 1'b0;
    logic [3:0] tgt_rate = 4'd0;
    logic       breathe = 1'b0;
    logic       tgt_ready;
    logic [7:0] level;
    logic       period_start;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_fade dut (
        .clk          (clk),
        .rstn         (rstn),
        .tgt_level    (tgt_level),
        .tgt_valid    (tgt_valid),
        .tgt_rate     (tgt_rate),
`ifdef PWM_FADE_BREATHE_EN
        .breathe      (breathe),
`endif
        .tgt_ready    (tgt_ready),
        .level        (level),
        .period_start (period_start),
        .busy         (busy)
    );

    typedef struct {
        logic       rstn;
        logic       vld;
        logic [7:0] tl;
        logic [3:0] tr;
        int         cyc;      // clock edges to run before sampling
        logic [7:0] e_level;
        logic       e_busy;
        logic       e_ready;
        logic       e_ps;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [7:0] tl, input logic [3:0] tr,
                       input int cyc, input logic [7:0] el, input logic eb, input logic er, input logic ep);
        vec_t x;
        x.rstn = r; x.vld = v; x.tl = tl; x.tr = tr; x.cyc = cyc;
        x.e_level = el; x.e_busy = eb; x.e_ready = er; x.e_ps = ep;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] el, input logic eb, input logic er, input logic ep);
        chk({tag, ".level"}, int'(level), int'(el));
        chk({tag, ".busy"}, int'(busy), int'(eb));
        chk({tag, ".tgt_ready"}, int'(tgt_ready), int'(er));
        chk({tag, ".period_start"}, int'(period_start), int'(ep));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tgt_valid = 1'b0;
        end
    endtask

    initial begin
        int n;
        logic [7:0] bexp[7];

        // Edge count k is measured from the reset-release negedge; the period
        // counter wraps on posedges k = 255, 510, ... which is when level may move.
        //   rstn vld tl   tr  cyc  level busy rdy ps
        add(0, 0, 8'd0,   0,   2,   8'd0,   0, 1, 1);  // in reset
        add(1, 1, 8'd3,   0,   1,   8'd0,   1, 0, 0);  // k=1 accept 3@rate0
        add(1, 0, 8'd0,   0,   253, 8'd0,   1, 0, 0);  // k=254 just before wrap
        add(1, 0, 8'd0,   0,   1,   8'd1,   1, 0, 1);  // k=255 first step
        add(1, 0, 8'd0,   0,   255, 8'd2,   1, 0, 1);  // k=510
        add(1, 0, 8'd0,   0,   255, 8'd3,   0, 1, 1);  // k=765 done, idle
        add(1, 1, 8'd3,   0,   1,   8'd3,   0, 1, 0);  // same level: never busy
        add(1, 1, 8'd200, 15,  1,   8'd3,   1, 0, 0);  // k=767 jump request
        add(1, 1, 8'd50,  0,   1,   8'd3,   1, 0, 0);  // valid while busy: dropped
        add(1, 0, 8'd0,   0,   252, 8'd200, 0, 1, 1);  // k=1020 jump lands on 200, not 50
        add(1, 1, 8'd198, 2,   1,   8'd200, 1, 0, 0);  // k=1021 down at rate 2
        add(1, 0, 8'd0,   0,   254, 8'd200, 1, 0, 1);  // k=1275 prescaler only
        add(1, 0, 8'd0,   0,   510, 8'd199, 1, 0, 1);  // k=1785 3rd boundary: step
        add(1, 0, 8'd0,   0,   765, 8'd198, 0, 1, 1);  // k=2550 6th boundary: done
        add(1, 1, 8'd10,  15,  1,   8'd198, 1, 0, 0);
        add(1, 0, 8'd0,   0,   254, 8'd10,  0, 1, 1);  // k=2805
        add(1, 1, 8'd250, 15,  1,   8'd10,  1, 0, 0);
        add(1, 0, 8'd0,   0,   254, 8'd250, 0, 1, 1);  // k=3060 jump 10->250
        add(1, 1, 8'd38,  15,  1,   8'd250, 1, 0, 0);
        add(1, 0, 8'd0,   0,   254, 8'd38,  0, 1, 1);  // k=3315
        add(1, 1, 8'd45,  0,   1,   8'd38,  1, 0, 0);
        add(1, 0, 8'd0,   0,   254, 8'd39,  1, 0, 1);  // k=3570
        add(1, 0, 8'd0,   0,   255, 8'd40,  1, 0, 1);  // k=3825
        add(1, 0, 8'd0,   0,   100, 8'd40,  1, 0, 0);  // mid-period at 40

        @(negedge clk);
        foreach (vecs[i]) begin
            rstn      = vecs[i].rstn;
            tgt_valid = vecs[i].vld;
            tgt_level = vecs[i].tl;
            tgt_rate  = vecs[i].tr;
            run_cycles(vecs[i].cyc);
            chk_all($sformatf("vec%0d", i), vecs[i].e_level, vecs[i].e_busy, vecs[i].e_ready, vecs[i].e_ps);
        end

        // Reset pulse while ramping at level 40.
        rstn = 1'b0;
        run_cycles(1);
        rstn = 1'b1;
        chk_all("rst_mid", 8'd0, 1'b0, 1'b1, 1'b1);
        n = 0;
        do begin
            run_cycles(1);
            n++;
        end while (!period_start && n < 400);
        chk("rst_mid.period_len", n, 255);
        chk_all("rst_mid.after", 8'd0, 1'b0, 1'b1, 1'b1);

`ifdef PWM_FADE_BREATHE_EN
        // Breathe between 0 and 2 at rate 0, then drop breathe on a down-ramp.
        bexp = '{8'd1, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd1};
        breathe   = 1'b1;
        tgt_level = 8'd2;
        tgt_rate  = 4'd0;
        tgt_valid = 1'b1;
        run_cycles(1);
        chk("br.busy_start", int'(busy), 1);
        for (int i = 0; i < 7; i++) begin
            run_cycles(i == 0 ? 254 : 255);
            chk($sformatf("br.level%0d", i), int'(level), int'(bexp[i]));
            chk($sformatf("br.busy%0d", i), int'(busy), 1);
            chk($sformatf("br.ready%0d", i), int'(tgt_ready), 0);
        end
        breathe = 1'b0;
        run_cycles(255);
        chk_all("br.settle", 8'd0, 1'b0, 1'b1, 1'b1);
        run_cycles(255);
        chk_all("br.stay", 8'd0, 1'b0, 1'b1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_fade.md
PWM_FADE -- requirements
Module: pwm_fade

Interface
REQ-001 SHALL have parameter: none; all timing is fixed by the 255-cycle PWM period.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock (same clock as downstream pwm_ctrl).
REQ-003 SHALL have port: rstn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: tgt_level  in  8  requested final PWM level.
REQ-005 SHALL have port: tgt_valid  in  1  tgt_level/tgt_rate valid.
REQ-006 SHALL have port: tgt_rate  in  4  PWM periods per step, minus 1; 15 = jump.
REQ-007 SHALL have port: tgt_ready  out  1  block can accept a new target.
REQ-008 SHALL have port: level  out  8  registered level driving pwm_ctrl.level.
REQ-009 SHALL have port: period_start  out  1  high in first cycle of each 255-cycle period.
REQ-010 SHALL have port: busy  out  1  ramp in progress.
REQ-011 SHALL have port (PWM_FADE_BREATHE_EN only): breathe  in  1  auto-reverse enable.

Function
REQ-012 SHALL run an 8-bit period counter 0..254, wrapping 254->0, matching pwm_ctrl's count sequence when both leave reset together.
REQ-013 SHALL assert period_start exactly when the period counter is 0.
REQ-014 SHALL change level only on the clock edge where the period counter goes 254->0, so level is constant across a full period.
REQ-015 SHALL implement states IDLE and RAMP; busy = (state == RAMP); tgt_ready = (state == IDLE).
REQ-016 SHALL accept a target when tgt_valid && tgt_ready, latching tgt_level and tgt_rate; valid without ready is ignored, with no queuing.
REQ-017 On acceptance with tgt_level == level: SHALL stay IDLE, with busy never asserted.
REQ-018 On acceptance with tgt_level != level: SHALL enter RAMP next cycle and clear the step prescaler to 0.
REQ-019 In RAMP, at each period boundary: if prescaler == latched rate, SHALL step level by +1 or -1 toward the target and clear the prescaler; otherwise SHALL increment the prescaler.
REQ-020 Rate 15 (jump): SHALL load level = target at the first period boundary after acceptance.
REQ-021 When a step or jump makes level equal to the target, SHALL return to IDLE on the same edge; tgt_ready is high the following cycle.
REQ-022 SHALL ensure level never overshoots the target and never wraps past 0 or 255 (saturating arithmetic, 8-bit).
REQ-023 Steps from the current level to target T at rate r SHALL complete in |T - level| * (r + 1) period boundaries.

Reset
REQ-024 While rstn=0 at a clock edge: level=0, period counter=0, prescaler=0, state=IDLE, latched target=0, latched rate=0.
REQ-025 After reset: tgt_ready=1, busy=0, period_start=1 in the first cycle after rstn rises.
REQ-026 Reset mid-ramp SHALL abandon the ramp and return level to 0 with no further steps.

Configuration
REQ-027 Macro PWM_FADE_BREATHE_EN SHALL compile in the breathe port and logic.
REQ-028 With the macro, breathe=1 at ramp completion SHALL auto-start a new ramp (same rate) to 0 if level == held target, or to the held target if level == 0; tgt_ready stays 0 while cycling.
REQ-029 With the macro, breathe=0 SHALL let the current ramp finish and then go IDLE; a held target of 0 never auto-restarts.
REQ-030 Without the macro, the breathe port SHALL be absent, and ramp completion always goes IDLE.

Verification
REQ-031 Reset, then target 3 at rate 0 -> level 1,2,3 at period boundaries 1,2,3 (cycles 255, 510, 765 after acceptance edge alignment); busy low after level=3.
REQ-032 Level 200, target 198 at rate 2 -> level 199 after 3 boundaries, 198 after 6; tgt_ready returns high.
REQ-033 Level 10, target 250 at rate 15 -> level=250 at the first boundary; busy for at most 255 cycles.
REQ-034 Level 5, target 5 -> tgt_ready stays 1, busy never 1; tgt_valid during RAMP -> ignored, target unchanged.
REQ-035 rstn pulsed low mid-ramp at level 40 -> level=0, IDLE, period_start high the cycle after release.
REQ-036 (macro on) Target 2, rate 0, breathe=1 -> level 1,2,1,0,1,2...; drop breathe while ramping down -> settles at 0, IDLE.
